// File: rtl/gift128_pkg.sv
// Shared constants, state type and constant-LFSR helper for the GIFT-128
// AddRoundKey stage.
package gift128_pkg;

  localparam int         GIFT_ROUNDS = 40;
  localparam logic [5:0] LAST_ROUND  = 6'(GIFT_ROUNDS - 1);
  localparam logic [5:0] RC_INIT     = 6'h01;

  // Bit positions inside each 4-bit nibble that receive key material.
  localparam int RK_U_BIT  = 2;
  localparam int RK_V_BIT  = 1;
  localparam int RC_BIT0   = 3;
  localparam int RC_STRIDE = 4;
  localparam int CONST_BIT = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ark_state_e;

  function automatic logic [5:0] next_rc(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift128_keysched.sv
// GIFT-128 key state register: loads the master key and advances one round
// per accept, presenting the U/V round-key words of the current round.
module gift128_keysched
  import gift128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic [127:0] key_in,
  output logic [31:0]  u,
  output logic [31:0]  v
);

  logic [127:0] key_r;
  logic [127:0] key_next_s;

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  // Next key: k1/k0 rotated into the top, k7..k2 shifted down.
  always_comb begin
    key_next_s = {rotr16(key_r[31:16], 2), rotr16(key_r[15:0], 12), key_r[127:32]};
  end

  // Key register; a load takes priority over an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= 128'd0;
    end else if (load) begin
      key_r <= key_in;
    end else if (advance) begin
      key_r <= key_next_s;
    end else begin
      key_r <= key_r;
    end
  end

  assign u = key_r[95:64];
  assign v = key_r[31:0];

endmodule

// File: rtl/gift128_addroundkey.sv
// Iterative GIFT-128 AddRoundKey stage: round FSM, counter, constant LFSR,
// XOR network and a registered valid/ready output.
module gift128_addroundkey
  import gift128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pout,
  output logic [5:0]   out_round,
  output logic         out_last,
  output logic         busy
);

  ark_state_e   state_r, next_state_s;
  logic [5:0]   round_r;
  logic [5:0]   rc_r;
  logic [31:0]  u_s, v_s;
  logic         in_ready_s, accept_s;
  logic [127:0] keyed_s;
  logic         out_valid_r, out_last_r, busy_r;
  logic [127:0] pout_r;
  logic [5:0]   out_round_r;

  gift128_keysched u_keysched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (key_load),
    .advance (accept_s),
    .key_in  (key_in),
    .u       (u_s),
    .v       (v_s)
  );

  // A key_load in the same cycle blocks acceptance so the abort wins.
  always_comb begin
    in_ready_s = (state_r == ST_RUN) && !key_load && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Round key, round constant and the fixed top bit XORed into the state.
  always_comb begin
    keyed_s = pin;
    for (int i = 0; i < 32; i++) begin
      keyed_s[4*i+RK_U_BIT] = pin[4*i+RK_U_BIT] ^ u_s[i];
      keyed_s[4*i+RK_V_BIT] = pin[4*i+RK_V_BIT] ^ v_s[i];
    end
    for (int j = 0; j < 6; j++) begin
      keyed_s[RC_BIT0+RC_STRIDE*j] = pin[RC_BIT0+RC_STRIDE*j] ^ rc_r[j];
    end
    keyed_s[CONST_BIT] = ~pin[CONST_BIT];
  end

  // Round sequencing.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (key_load) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (key_load)                             next_state_s = ST_RUN;
        else if (accept_s && round_r == LAST_ROUND) next_state_s = ST_DONE;
        else                                      next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (key_load) next_state_s = ST_RUN;
        else          next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, round counter and constant LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      round_r <= 6'd0;
      rc_r    <= 6'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN);
      if (key_load) begin
        round_r <= 6'd0;
        rc_r    <= RC_INIT;
      end else if (accept_s) begin
        round_r <= round_r + 6'd1;
        rc_r    <= next_rc(rc_r);
      end else begin
        round_r <= round_r;
        rc_r    <= rc_r;
      end
    end
  end

  // Output register; data only changes on accept so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      pout_r      <= 128'd0;
      out_round_r <= 6'd0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      pout_r      <= keyed_s;
      out_round_r <= round_r;
      out_last_r  <= (round_r == LAST_ROUND);
    end else begin
      out_valid_r <= out_valid_r && !out_ready;
      pout_r      <= pout_r;
      out_round_r <= out_round_r;
      out_last_r  <= out_last_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign pout      = pout_r;
  assign out_round = out_round_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_gift128_addroundkey.sv
// Scoreboard bench for gift128_addroundkey: an independent round model pushes
// expected outputs on accept; they are compared whenever the DUT presents them.
module tb_gift128_addroundkey;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = 128'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] pin = 128'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] pout;
  logic [5:0]   out_round;
  logic         out_last;
  logic         busy;

  gift128_addroundkey dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pin       (pin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pout      (pout),
    .out_round (out_round),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] p;
    logic [5:0]   r;
    logic         l;
  } exp_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           m_state = M_IDLE;
  int           m_round = 0;
  logic         m_ov = 1'b0;
  logic [127:0] m_key = 128'd0;
  logic [5:0]   m_rc = 6'd0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] p, input logic [127:0] k,
                                               input logic [5:0] c);
    logic [127:0] r;
    logic [31:0]  uu, vv;
    r  = p;
    uu = k[95:64];
    vv = k[31:0];
    for (int i = 0; i < 32; i++) begin
      r[4*i+2] = r[4*i+2] ^ uu[i];
      r[4*i+1] = r[4*i+1] ^ vv[i];
    end
    r[3]   = r[3]  ^ c[0];
    r[7]   = r[7]  ^ c[1];
    r[11]  = r[11] ^ c[2];
    r[15]  = r[15] ^ c[3];
    r[19]  = r[19] ^ c[4];
    r[23]  = r[23] ^ c[5];
    r[127] = ~r[127];
    return r;
  endfunction

  task automatic cycle(input logic kl, input logic [127:0] kin, input logic iv,
                       input logic [127:0] p, input logic ordy);
    logic exp_rdy, acc;
    exp_t e;
    @(negedge clk);
    key_load  = kl;
    key_in    = kin;
    in_valid  = iv;
    pin       = p;
    out_ready = ordy;
    #1;
    exp_rdy = (m_state == M_RUN) && !kl && (!m_ov || ordy);
    check("in_ready", 128'(in_ready), 128'(exp_rdy));
    check("out_valid", 128'(out_valid), 128'(m_ov));
    check("busy", 128'(busy), 128'(m_state == M_RUN));
    if (m_ov && q.size() > 0) begin
      e = q[0];
      check("pout", pout, e.p);
      check("out_round", 128'(out_round), 128'(e.r));
      check("out_last", 128'(out_last), 128'(e.l));
      if (ordy) void'(q.pop_front());
    end
    acc = iv && exp_rdy;
    if (acc) begin
      e.p = model_round(p, m_key, m_rc);
      e.r = 6'(m_round);
      e.l = (m_round == 39);
      q.push_back(e);
      m_key   = {m_key[17:16], m_key[31:18], m_key[11:0], m_key[15:12], m_key[127:32]};
      m_rc    = {m_rc[4:0], ~(m_rc[5] ^ m_rc[4])};
      m_round = m_round + 1;
      if (m_round == 40) m_state = M_DONE;
    end
    if (kl) begin
      m_key   = kin;
      m_round = 0;
      m_rc    = 6'h01;
      m_state = M_RUN;
    end
    m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pout"}, pout, 128'd0);
    check({tag, "_round"}, 128'(out_round), 128'd0);
    check({tag, "_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_last"}, 128'(out_last), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd0);
  endtask

  initial begin
    logic [127:0] rk;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero key, zero state: four rounds of constant progression.
    cycle(1'b1, 128'd0, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b1, 128'd0, 1'b1);
    @(posedge clk); #1;
    check("zero_r0", pout, 128'h8000_0000_0000_0000_0000_0000_0000_0008);
    for (int i = 0; i < 3; i++) cycle(1'b0, 128'd0, 1'b1, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b0, 128'd0, 1'b1);

    // k0 = 1 reaches bit 1 of round 0.
    cycle(1'b1, 128'd1, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b1, 128'd0, 1'b1);
    @(posedge clk); #1;
    check("key1_r0", pout, 128'h8000_0000_0000_0000_0000_0000_0000_000A);

    // Full 40-round run with random data, then a 41st attempt.
    rk = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, rk, 1'b0, 128'd0, 1'b1);
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // Backpressure: one transfer held for 3 cycles, then drain and next round.
    cycle(1'b1, rk, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b1, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    cycle(1'b0, 128'd0, 1'b1, 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0, 1'b1);
    cycle(1'b0, 128'd0, 1'b0, 128'd0, 1'b1);

    // Reload at round 17 with in_valid high.
    rk = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, rk, 1'b0, 128'd0, 1'b1);
    for (int i = 0; i < 17; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    cycle(1'b1, ~rk, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 60; i++)
      cycle(1'b0, 128'd0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)));

    // Asynchronous reset mid-run.
    cycle(1'b1, rk, 1'b0, 128'd0, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 128'd0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    check_zero_outputs("async_rst");
    q.delete();
    m_state = M_IDLE;
    m_ov    = 1'b0;
    m_round = 0;
    m_key   = 128'd0;
    m_rc    = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 128'd0, 1'b1, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b0, 128'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
